// File: rtl/alu_ctrl_mc_if.sv
// Decode/handshake bundle between the ID/EX stage and the multi-cycle ALU control unit.
// The master side presents instructions; the slave side returns the registered control and status.
interface alu_ctrl_mc_if;
    logic       valid_i;
    logic       flush_i;
    logic [9:0] funct_i;
    logic [1:0] ALUOp_i;
    logic [3:0] ALUCtrl_o;
    logic       busy_o;
    logic       done_o;
    logic       illegal_o;

    modport master (
        output valid_i, flush_i, funct_i, ALUOp_i,
        input  ALUCtrl_o, busy_o, done_o, illegal_o
    );

    modport slave (
        input  valid_i, flush_i, funct_i, ALUOp_i,
        output ALUCtrl_o, busy_o, done_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU control: registered opcode decode plus MUL/DIV busy/done sequencing.
// Define ALU_CTRL_DIV_EN to decode R-type funct 0000001100 as DIV with DIV_CYCLES latency.
module alu_ctrl_mc #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    alu_ctrl_mc_if.slave bus_if
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_SRAI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam bit PARAMS_OK = (MUL_CYCLES >= 1) && (MUL_CYCLES <= 15) &&
                               (DIV_CYCLES >= 1) && (DIV_CYCLES <= 15);

    if (!PARAMS_OK) begin : g_param_check
        $error("alu_ctrl_mc: MUL_CYCLES and DIV_CYCLES must lie in 1..15");
    end

    // Counter preload is K-2 so the last busy cycle is the one where the counter reads zero.
    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [3:0] OP_DIV    = 4'b1011;
    localparam bit         DIV_MULTI = (DIV_CYCLES > 1);
    localparam logic [3:0] DIV_LOAD  = DIV_MULTI ? 4'(DIV_CYCLES - 2) : 4'd0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] alu_ctrl_q;
    logic       busy_q;
    logic       done_q;
    logic       illegal_q;

    logic [3:0] dec_code_s;
    logic       dec_illegal_s;
    logic       dec_multi_s;
    logic [3:0] dec_load_s;

    // Opcode decode of the presented instruction; fully specified so no latch can form.
    always_comb begin
        dec_code_s    = OP_NOP;
        dec_illegal_s = 1'b1;
        dec_multi_s   = 1'b0;
        dec_load_s    = 4'd0;
        case (bus_if.ALUOp_i)
            2'b10: begin
                case (bus_if.funct_i)
                    10'b0000000111: begin dec_code_s = OP_AND; dec_illegal_s = 1'b0; end
                    10'b0000000100: begin dec_code_s = OP_XOR; dec_illegal_s = 1'b0; end
                    10'b0000000001: begin dec_code_s = OP_SLL; dec_illegal_s = 1'b0; end
                    10'b0000000000: begin dec_code_s = OP_ADD; dec_illegal_s = 1'b0; end
                    10'b0100000000: begin dec_code_s = OP_SUB; dec_illegal_s = 1'b0; end
                    10'b0000001000: begin
                        dec_code_s    = OP_MUL;
                        dec_illegal_s = 1'b0;
                        dec_multi_s   = MUL_MULTI;
                        dec_load_s    = MUL_LOAD;
                    end
`ifdef ALU_CTRL_DIV_EN
                    10'b0000001100: begin
                        dec_code_s    = OP_DIV;
                        dec_illegal_s = 1'b0;
                        dec_multi_s   = DIV_MULTI;
                        dec_load_s    = DIV_LOAD;
                    end
`endif
                    default: begin dec_code_s = OP_NOP; dec_illegal_s = 1'b1; end
                endcase
            end
            2'b00: begin
                case (bus_if.funct_i[2:0])
                    3'b000:  begin dec_code_s = OP_ADDI; dec_illegal_s = 1'b0; end
                    3'b101:  begin dec_code_s = OP_SRAI; dec_illegal_s = 1'b0; end
                    3'b010:  begin dec_code_s = OP_LW;   dec_illegal_s = 1'b0; end
                    default: begin dec_code_s = OP_NOP;  dec_illegal_s = 1'b1; end
                endcase
            end
            2'b01:   begin dec_code_s = OP_SW;  dec_illegal_s = 1'b0; end
            2'b11:   begin dec_code_s = OP_BEQ; dec_illegal_s = 1'b0; end
            default: begin dec_code_s = OP_NOP; dec_illegal_s = 1'b1; end
        endcase
    end

    // Sequencer: accepts ops when not busy, counts multi-cycle latency, flush aborts silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            alu_ctrl_q <= OP_NOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (bus_if.flush_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            alu_ctrl_q <= OP_NOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    if (bus_if.valid_i) begin
                        alu_ctrl_q <= dec_code_s;
                        if (dec_multi_s) begin
                            state_q <= BUSY;
                            cnt_q   <= dec_load_s;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q    <= 1'b1;
                            illegal_q <= dec_illegal_s;
                        end
                    end
                end
                BUSY: begin
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= 4'd0;
                    alu_ctrl_q <= OP_NOP;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    illegal_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.ALUCtrl_o = alu_ctrl_q;
    assign bus_if.busy_o    = busy_q;
    assign bus_if.done_o    = done_q;
    assign bus_if.illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Scoreboard bench for alu_ctrl_mc: directed ops push expected responses, a negedge monitor checks them.
module tb_alu_ctrl_mc;

    localparam int MUL_K = 3;
    localparam int DIV_K = 8;

    typedef struct {
        logic [3:0] code;
        logic       ill;
        int         acc;
        int         done_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   free_edge = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic exp_busy;

    alu_ctrl_mc_if bus ();

    alu_ctrl_mc #(.MUL_CYCLES(MUL_K), .DIV_CYCLES(DIV_K)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_if(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Present an op; hold valid until the model says it is accepted, then push its expected response.
    task automatic issue(input logic [1:0] op, input logic [9:0] fn,
                         input logic [3:0] code, input logic ill, input int k);
        int   e;
        int   acc;
        exp_t x;
        e   = cyc + 1;
        acc = (e > free_edge) ? e : free_edge;
        bus.valid_i = 1'b1;
        bus.ALUOp_i = op;
        bus.funct_i = fn;
        x.code    = code;
        x.ill     = ill;
        x.acc     = acc;
        x.done_at = acc + k - 1;
        sb_q.push_back(x);
        free_edge = acc + k;
        repeat (acc - e + 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: busy window, held control while busy, and each done/illegal response against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].acc) && (cyc < sb_q[0].done_at);
            chk("busy", {31'd0, bus.busy_o}, {31'd0, exp_busy});
            if (exp_busy)
                chk("held_ctrl", {28'd0, bus.ALUCtrl_o}, {28'd0, sb_q[0].code});
            if (bus.done_o || (sb_q.size() > 0 && cyc == sb_q[0].done_at)) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_done at edge %0d: got done_o=1 expected no pending op", cyc);
                end else begin
                    chk("done_pulse", {31'd0, bus.done_o}, 32'd1);
                    chk("done_edge", cyc, sb_q[0].done_at);
                    chk("ctrl", {28'd0, bus.ALUCtrl_o}, {28'd0, sb_q[0].code});
                    chk("illegal", {31'd0, bus.illegal_o}, {31'd0, sb_q[0].ill});
                    void'(sb_q.pop_front());
                end
            end else begin
                chk("no_illegal", {31'd0, bus.illegal_o}, 32'd0);
            end
        end
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.funct_i = 10'd0;
        bus.ALUOp_i = 2'b00;

        // Reset asserted between edges must drive outputs immediately.
        #1 rst = 1'b1;
        #1;
        chk("rst_ctrl", {28'd0, bus.ALUCtrl_o}, 32'hF);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal_o}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // R-type sweep, back to back; ADD after MUL is held through the stall.
        issue(2'b10, 10'b0000000111, 4'b0000, 1'b0, 1);
        issue(2'b10, 10'b0000000100, 4'b0001, 1'b0, 1);
        issue(2'b10, 10'b0000000001, 4'b0010, 1'b0, 1);
        issue(2'b10, 10'b0000000000, 4'b0011, 1'b0, 1);
        issue(2'b10, 10'b0100000000, 4'b0100, 1'b0, 1);
        issue(2'b10, 10'b0000001000, 4'b0101, 1'b0, MUL_K);
        issue(2'b10, 10'b0000000000, 4'b0011, 1'b0, 1);
        idle(3);
        chk("hold_ctrl_idle", {28'd0, bus.ALUCtrl_o}, 32'h3);

        // I, S and SB types; I-type ignores funct7.
        issue(2'b00, 10'b1111111000, 4'b0110, 1'b0, 1);
        issue(2'b00, 10'b0000000101, 4'b0111, 1'b0, 1);
        issue(2'b00, 10'b0000000010, 4'b1000, 1'b0, 1);
        issue(2'b01, 10'b1010101010, 4'b1001, 1'b0, 1);
        issue(2'b11, 10'b0101010101, 4'b1010, 1'b0, 1);
        idle(2);

        // Illegal encodings, then a legal op right behind them.
        issue(2'b00, 10'b0000000011, 4'b1111, 1'b1, 1);
`ifdef ALU_CTRL_DIV_EN
        issue(2'b10, 10'b0000001100, 4'b1011, 1'b0, DIV_K);
`else
        issue(2'b10, 10'b0000001100, 4'b1111, 1'b1, 1);
`endif
        issue(2'b10, 10'b0000000010, 4'b1111, 1'b1, 1);
        issue(2'b10, 10'b0100000000, 4'b0100, 1'b0, 1);
        idle(2);

        // Flush in the first busy cycle of MUL, with an SW co-presented.
        issue(2'b10, 10'b0000001000, 4'b0101, 1'b0, MUL_K);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.ALUOp_i = 2'b01;
        bus.funct_i = 10'd0;
        @(posedge clk);
        #1;
        sb_q.delete();
        free_edge = 0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("flush_ctrl", {28'd0, bus.ALUCtrl_o}, 32'hF);
        idle(6);

        // Flush while idle beats a co-presented ADD and forces NOP.
        issue(2'b11, 10'd0, 4'b1010, 1'b0, 1);
        idle(1);
        bus.flush_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.ALUOp_i = 2'b10;
        bus.funct_i = 10'b0000000000;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("idle_flush_ctrl", {28'd0, bus.ALUCtrl_o}, 32'hF);
        idle(2);

`ifdef ALU_CTRL_DIV_EN
        // DIV with an op presented throughout the busy window, which must be ignored until done.
        issue(2'b10, 10'b0000001100, 4'b1011, 1'b0, DIV_K);
        issue(2'b10, 10'b0000000111, 4'b0000, 1'b0, 1);
        idle(2);
`endif

        // Reset mid-MUL, between clock edges.
        issue(2'b10, 10'b0000001000, 4'b0101, 1'b0, MUL_K);
        bus.valid_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        free_edge = 0;
        chk("midop_rst_ctrl", {28'd0, bus.ALUCtrl_o}, 32'hF);
        chk("midop_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("midop_rst_done", {31'd0, bus.done_o}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'b10, 10'b0000000100, 4'b0001, 1'b0, 1);
        idle(4);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
